// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: RV64I opcodes, immediate formats,
// the bubble encoding and the EX control bundle.
package id_stage_pkg;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jal;
    logic jalr;
    logic alu_src;
    logic lui;
    logic auipc;
    logic word_op;
  } ctrl_t;

endpackage

// File: rtl/id_stage_imm_gen.sv
// Combinational immediate extraction; every format sign-extends from instr[31].
module id_stage_imm_gen
  import id_stage_pkg::*;
(
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
    case (imm_type)
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV64I decode stage: IF/ID register, decoder and load-use stall; one-cycle latency
// from fetch to id_* outputs, flush turns the latched instruction into a bubble.
module id_stage
  import id_stage_pkg::*;
(
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic            stall_id_reg,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [XLEN-1:0] id_imm,
  output logic            id_reg_write,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_branch,
  output logic            id_jal,
  output logic            id_jalr,
  output logic            id_alu_src,
  output logic            id_lui,
  output logic            id_auipc,
  output logic            id_word_op,
  output logic            id_illegal
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  logic [6:0] opcode;
  ctrl_t      ctrl, ctrl_out;
  imm_type_e  imm_type;
  logic       legal, rs1_used, rs2_used, hazard;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Flush outranks the stall so a redirect never keeps a stale instruction.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall_id_reg) begin
      pc_d    = if_pc;
      instr_d = if_instr;
      valid_d = 1'b1;
    end
  end

  assign opcode = instr_q[6:0];

  always_comb begin
    ctrl     = '0;
    legal    = 1'b1;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    imm_type = IMM_I;
    case (opcode)
      OPC_LUI:     begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.lui = 1'b1;
                         rs1_used = 1'b0; imm_type = IMM_U; end
      OPC_AUIPC:   begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.auipc = 1'b1;
                         rs1_used = 1'b0; imm_type = IMM_U; end
      OPC_JAL:     begin ctrl.reg_write = 1'b1; ctrl.jal = 1'b1;
                         rs1_used = 1'b0; imm_type = IMM_J; end
      OPC_JALR:    begin ctrl.reg_write = 1'b1; ctrl.jalr = 1'b1; ctrl.alu_src = 1'b1; end
      OPC_BRANCH:  begin ctrl.branch = 1'b1; rs2_used = 1'b1; imm_type = IMM_B; end
      OPC_LOAD:    begin ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; ctrl.alu_src = 1'b1; end
      OPC_STORE:   begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; rs2_used = 1'b1;
                         imm_type = IMM_S; end
      OPC_OPIMM:   begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; end
      OPC_OPIMM32: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.word_op = 1'b1; end
      OPC_OP:      begin ctrl.reg_write = 1'b1; rs2_used = 1'b1; end
      OPC_OP32:    begin ctrl.reg_write = 1'b1; ctrl.word_op = 1'b1; rs2_used = 1'b1; end
      default:     legal = 1'b0;
    endcase
  end

  id_stage_imm_gen u_imm_gen (
    .instr    (instr_q),
    .imm_type (imm_type),
    .imm      (id_imm)
  );

  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  ((rs1_used && (ex_rd == instr_q[19:15])) ||
                   (rs2_used && (ex_rd == instr_q[24:20])));
  assign stall_id_reg = valid_q && hazard && !flush;
  assign id_valid     = valid_q && !stall_id_reg && !flush;

  // Bubbles carry no side effects into EX; writes to x0 are dropped here too.
  always_comb begin
    ctrl_out = id_valid ? ctrl : '0;
    if (instr_q[11:7] == 5'd0) ctrl_out.reg_write = 1'b0;
  end

  assign id_pc        = pc_q;
  assign id_rs1       = instr_q[19:15];
  assign id_rs2       = instr_q[24:20];
  assign id_rd        = instr_q[11:7];
  assign id_funct3    = instr_q[14:12];
  assign id_funct7    = instr_q[31:25];
  assign id_reg_write = ctrl_out.reg_write;
  assign id_mem_read  = ctrl_out.mem_read;
  assign id_mem_write = ctrl_out.mem_write;
  assign id_branch    = ctrl_out.branch;
  assign id_jal       = ctrl_out.jal;
  assign id_jalr      = ctrl_out.jalr;
  assign id_alu_src   = ctrl_out.alu_src;
  assign id_lui       = ctrl_out.lui;
  assign id_auipc     = ctrl_out.auipc;
  assign id_word_op   = ctrl_out.word_op;
  assign id_illegal   = valid_q && !legal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed pipeline scenarios plus random traffic against a
// behavioural model of the IF/ID register and decode rules.
module tb_id_stage;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [63:0] if_pc = '0;
  logic [31:0] if_instr = 32'h13;
  logic        flush = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        stall_id_reg, id_valid, id_illegal;
  logic [63:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic id_reg_write, id_mem_read, id_mem_write, id_branch, id_jal, id_jalr;
  logic id_alu_src, id_lui, id_auipc, id_word_op;

  int checks = 0;
  int errors = 0;

  // Model of the IF/ID register contents.
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;

  always #5 sys_clk = ~sys_clk;

  id_stage dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .stall_id_reg(stall_id_reg), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_jal(id_jal), .id_jalr(id_jalr), .id_alu_src(id_alu_src),
    .id_lui(id_lui), .id_auipc(id_auipc), .id_word_op(id_word_op), .id_illegal(id_illegal)
  );

  function automatic logic [9:0] dut_ctl();
    return {id_reg_write, id_mem_read, id_mem_write, id_branch, id_jal,
            id_jalr, id_alu_src, id_lui, id_auipc, id_word_op};
  endfunction

  // Control table: {reg_write,mem_read,mem_write,branch,jal,jalr,alu_src,lui,auipc,word_op}
  function automatic logic [10:0] m_table(input logic [6:0] opc);
    logic [9:0] c;
    logic ok;
    ok = 1'b1;
    case (opc)
      7'b0110111: c = 10'b1000001100;
      7'b0010111: c = 10'b1000001010;
      7'b1101111: c = 10'b1000100000;
      7'b1100111: c = 10'b1000011000;
      7'b1100011: c = 10'b0001000000;
      7'b0000011: c = 10'b1100001000;
      7'b0100011: c = 10'b0010001000;
      7'b0010011: c = 10'b1000001000;
      7'b0011011: c = 10'b1000001001;
      7'b0110011: c = 10'b1000000000;
      7'b0111011: c = 10'b1000000001;
      default: begin c = '0; ok = 1'b0; end
    endcase
    return {ok, c};
  endfunction

  function automatic logic [63:0] m_imm(input logic [31:0] i);
    longint v;
    case (i[6:0])
      7'b0110111, 7'b0010111: v = longint'($signed(i[31:12])) * 4096;
      7'b1101111: v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
      7'b1100011: v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
      7'b0100011: v = longint'($signed({i[31:25], i[11:7]}));
      default:    v = longint'($signed(i[31:20]));
    endcase
    return v;
  endfunction

  function automatic logic m_stall();
    logic [6:0] opc;
    logic u1, u2;
    opc = m_instr[6:0];
    u1 = !(opc == 7'b0110111 || opc == 7'b0010111 || opc == 7'b1101111);
    u2 = (opc == 7'b1100011 || opc == 7'b0100011 || opc == 7'b0110011 || opc == 7'b0111011);
    return m_valid && ex_mem_read && ex_rd != 0 && !flush &&
           ((u1 && ex_rd == m_instr[19:15]) || (u2 && ex_rd == m_instr[24:20]));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic st, v;
    logic [10:0] t;
    logic [9:0] c;
    st = m_stall();
    v  = m_valid && !st && !flush;
    t  = m_table(m_instr[6:0]);
    c  = v ? t[9:0] : 10'b0;
    if (m_instr[11:7] == 0) c[9] = 1'b0;
    chk("stall", stall_id_reg, st);
    chk("valid", id_valid, v);
    chk("pc", id_pc, m_pc);
    chk("fields", {id_rs1, id_rs2, id_rd, id_funct3, id_funct7},
        {m_instr[19:15], m_instr[24:20], m_instr[11:7], m_instr[14:12], m_instr[31:25]});
    chk("imm", id_imm, m_imm(m_instr));
    chk("ctl", dut_ctl(), c);
    chk("illegal", id_illegal, m_valid && !t[10]);
  endtask

  task automatic apply(input logic [63:0] pc, input logic [31:0] ins, input logic fl,
                       input logic mr, input logic [4:0] rd, input logic rst);
    if_pc = pc; if_instr = ins; flush = fl; ex_mem_read = mr; ex_rd = rd; sys_rst = rst;
    #1;
    compare_model();
  endtask

  task automatic tick();
    logic st;
    @(posedge sys_clk);
    st = m_stall();
    if (sys_rst || flush) begin
      m_pc = '0; m_instr = 32'h13; m_valid = 1'b0;
    end else if (!st) begin
      m_pc = if_pc; m_instr = if_instr; m_valid = 1'b1;
    end
    @(negedge sys_clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stall"}, stall_id_reg, 1'b0);
    chk({tag, "_valid"}, id_valid, 1'b0);
    chk({tag, "_pc"}, id_pc, 64'd0);
    chk({tag, "_imm"}, id_imm, 64'd0);
    chk({tag, "_ctl"}, dut_ctl(), 10'd0);
    chk({tag, "_illegal"}, id_illegal, 1'b0);
  endtask

  initial begin
    logic [6:0] opcs [12];
    logic [31:0] r;
    opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
             7'b0100011, 7'b0010011, 7'b0011011, 7'b0110011, 7'b0111011, 7'b1111111};
    @(negedge sys_clk);
    sys_rst = 1'b1;
    tick();
    tick();

    apply(64'h8000_0000, 32'h00500093, 0, 0, 0, 0);  // addi x1,x0,5
    chk_reset_vals("rst0");
    tick();
    apply(64'h8000_0004, 32'hFE000EE3, 0, 0, 0, 0);  // beq x0,x0,-4
    chk("addi_valid", id_valid, 1'b1);
    chk("addi_rd", id_rd, 5'd1);
    chk("addi_rs1", id_rs1, 5'd0);
    chk("addi_imm", id_imm, 64'd5);
    chk("addi_rw", id_reg_write, 1'b1);
    chk("addi_alusrc", id_alu_src, 1'b1);
    chk("addi_pc", id_pc, 64'h8000_0000);
    tick();
    apply(64'h8000_0008, 32'h800000B7, 0, 0, 0, 0);  // lui x1,0x80000
    chk("beq_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_branch", id_branch, 1'b1);
    tick();
    apply(64'h8000_000C, 32'h002081B3, 0, 0, 0, 0);  // add x3,x1,x2
    chk("lui_imm", id_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_flag", id_lui, 1'b1);
    tick();
    apply(64'h8000_0010, 32'h00000033, 0, 1, 5'd1, 0);
    chk("lu_stall", stall_id_reg, 1'b1);
    chk("lu_valid", id_valid, 1'b0);
    tick();
    apply(64'h8000_0010, 32'h000282B7, 0, 0, 0, 0);   // lui x5,0x28 (rs1 field = 5)
    chk("lu_release", id_valid, 1'b1);
    chk("lu_held_pc", id_pc, 64'h8000_000C);
    chk("lu_held_rd", id_rd, 5'd3);
    tick();
    apply(64'h8000_0014, 32'h002081B3, 0, 1, 5'd5, 0);
    chk("lui_nostall", stall_id_reg, 1'b0);
    chk("lui_valid", id_valid, 1'b1);
    tick();
    apply(64'h8000_0018, 32'h002081B3, 0, 1, 5'd0, 0);
    chk("x0_nostall", stall_id_reg, 1'b0);
    tick();
    apply(64'h8000_001C, 32'hFFFFFFFF, 1, 1, 5'd1, 0);
    chk("fl_stall", stall_id_reg, 1'b0);
    chk("fl_valid", id_valid, 1'b0);
    tick();
    apply(64'h8000_0020, 32'hFFFFFFFF, 0, 0, 0, 0);
    chk("fl_bubble_valid", id_valid, 1'b0);
    chk("fl_bubble_pc", id_pc, 64'd0);
    chk("fl_bubble_rd", id_rd, 5'd0);
    tick();
    apply(64'h8000_0024, 32'h00000013, 0, 0, 0, 0);
    chk("ill_flag", id_illegal, 1'b1);
    chk("ill_ctl", dut_ctl(), 10'd0);
    tick();
    apply(64'h8000_0028, 32'h00000013, 0, 0, 0, 1);
    tick();
    apply(64'h8000_002C, 32'h00000013, 0, 1, 5'd1, 0);
    chk_reset_vals("rst1");
    tick();

    for (int n = 0; n < 2000; n++) begin
      r = $urandom;
      r[6:0]   = opcs[$urandom_range(0, 11)];
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      r[11:7]  = 5'($urandom_range(0, 3));
      apply({$urandom, $urandom}, r, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 49) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
